// File: rtl/ram_load_arbiter.sv
// Arbitrates the program RAM load port between a host loader and the CPU core.
// Sequences load, settle, run and halt, and drives the core's active-low reset.
module ram_load_arbiter #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_RUN       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              start,
  input  logic              cpu_hlt,
  output logic              host_ack,
  output logic              input_mode,
  output logic [ADDR_W-1:0] input_address,
  output logic [DATA_W-1:0] input_program,
  output logic              cpu_reset,
  output logic              busy,
  output logic [4:0]        bytes_loaded,
  output logic              run_done,
  output logic              timeout
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StHalted = 3'd4;

  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] MaxRun     = 16'(MAX_RUN);
  localparam bit          WdEn       = (MAX_RUN != 0);

  logic [2:0]        state_q, state_d;
  logic              armed_q, armed_d;
  logic              last_q, last_d;
  logic [3:0]        settle_q, settle_d;
  logic [15:0]       wd_q, wd_d, wd_inc;
  logic              host_ack_q, host_ack_d;
  logic              input_mode_q, input_mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic [4:0]        bytes_q, bytes_d;
  logic              run_done_q, run_done_d;
  logic              timeout_q, timeout_d;

  assign wd_inc = wd_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    last_d       = last_q;
    settle_d     = settle_q;
    wd_d         = wd_q;
    host_ack_d   = 1'b0;
    input_mode_d = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    cpu_reset_d  = cpu_reset_q;
    bytes_d      = bytes_q;
    run_done_d   = run_done_q;
    timeout_d    = timeout_q;

    case (state_q)
      StIdle, StHalted: begin
        if (host_req) begin
          state_d     = StLoad;
          cpu_reset_d = 1'b0;
          run_done_d  = 1'b0;
          timeout_d   = 1'b0;
          bytes_d     = 5'd0;
          armed_d     = 1'b1;
          last_d      = 1'b0;
        end else if (start) begin
          state_d     = StSettle;
          settle_d    = 4'd0;
          cpu_reset_d = 1'b0;
          run_done_d  = 1'b0;
          timeout_d   = 1'b0;
          wd_d        = 16'd0;
        end
      end
      StLoad: begin
        if (host_ack_q && last_q) begin
          state_d     = StSettle;
          settle_d    = 4'd0;
          cpu_reset_d = 1'b0;
          run_done_d  = 1'b0;
          timeout_d   = 1'b0;
          wd_d        = 16'd0;
        end else if (host_req && !host_ack_q && armed_q) begin
          addr_d       = host_addr;
          data_d       = host_data;
          input_mode_d = 1'b1;
          host_ack_d   = 1'b1;
          armed_d      = 1'b0;
          last_d       = host_last;
          if (bytes_q != 5'd16) bytes_d = bytes_q + 5'd1;
        end else if (!host_req) begin
          // Re-arm only once req drops so a held req writes exactly once.
          armed_d = 1'b1;
        end
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d     = StRun;
          cpu_reset_d = 1'b1;
          wd_d        = 16'd0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StRun: begin
        wd_d = wd_inc;
        if (cpu_hlt) begin
          state_d    = StHalted;
          run_done_d = 1'b1;
        end else if (WdEn && (wd_inc == MaxRun)) begin
          state_d     = StHalted;
          timeout_d   = 1'b1;
          cpu_reset_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLoad) || (state_d == StSettle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      last_q       <= 1'b0;
      settle_q     <= 4'd0;
      wd_q         <= 16'd0;
      host_ack_q   <= 1'b0;
      input_mode_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      bytes_q      <= 5'd0;
      run_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      last_q       <= last_d;
      settle_q     <= settle_d;
      wd_q         <= wd_d;
      host_ack_q   <= host_ack_d;
      input_mode_q <= input_mode_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      bytes_q      <= bytes_d;
      run_done_q   <= run_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign host_ack      = host_ack_q;
  assign input_mode    = input_mode_q;
  assign input_address = addr_q;
  assign input_program = data_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign bytes_loaded  = bytes_q;
  assign run_done      = run_done_q;
  assign timeout       = timeout_q;

endmodule

// File: doc/ram_load_arbiter.md
Name: ram_load_arbiter

Overview:
- Owns the 16x8 program RAM between two users: an external host loader and the CPU core.
- During load it holds the CPU in reset and drives the RAM load port (input_mode/input_address/input_program) through a req/ack handshake.
- After load it releases the CPU, supervises execution until HLT or a watchdog timeout, and then allows reload or re-run.
- Sits between the host/bench and the RAM load port, and drives the core's active-low reset.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width (opcode:operand).
- SETTLE_CYCLES, 2, cycles the CPU is held in reset after load, before release (1..15).
- MAX_RUN, 0, watchdog limit in RUN cycles; 0 disables it. Counter is 16 bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- host_req  in  1  host beat request; level, held until host_ack.
- host_addr  in  ADDR_W  RAM address of beat.
- host_data  in  DATA_W  program/data word of beat.
- host_last  in  1  marks final beat of load.
- start  in  1  request to run the program currently in RAM.
- cpu_hlt  in  1  HLT from control sequencer.
- host_ack  out  1  one-cycle beat acknowledge.
- input_mode  out  1  RAM load-write strobe.
- input_address  out  ADDR_W  RAM load address.
- input_program  out  DATA_W  RAM load data.
- cpu_reset  out  1  active-low reset to core; 0 = CPU held.
- busy  out  1  high in LOAD or SETTLE.
- bytes_loaded  out  5  accepted beats since load entry, saturating at 16.
- run_done  out  1  CPU halted normally.
- timeout  out  1  watchdog fired.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE; cpu_reset=0; input_mode=0; input_address=0; input_program=0.
  - host_ack=0; busy=0; bytes_loaded=0; run_done=0; timeout=0; all counters 0.
  - Applies in any state. Reset mid-LOAD aborts with no further write strobes; an in-flight ack is dropped.
- States: IDLE, LOAD, SETTLE, RUN, HALTED. All outputs are registered.
- IDLE:
  - host_req=1 -> LOAD; bytes_loaded cleared.
  - start=1 with host_req=0 -> SETTLE.
  - If both are high, host_req wins.
- LOAD:
  - Accept a beat when host_req=1, host_ack=0, and the armed flag is set.
  - Cycle after acceptance: input_address/input_program take host_addr/host_data; input_mode=1 and host_ack=1 for exactly that one cycle; bytes_loaded increments (saturates at 16).
  - Latency from accepted req edge to strobe/ack is 1 cycle.
  - The armed flag clears on acceptance and re-sets only when host_req is sampled 0, so one held req yields exactly one write.
  - Repeated addresses are written again and counted again.
  - If host_last=1 on the accepted beat, go to SETTLE after the ack cycle.
  - start is ignored in LOAD.
  - input_address/input_program hold their last values between strobes.
- SETTLE:
  - cpu_reset=0, input_mode=0 for SETTLE_CYCLES cycles, then RUN.
  - run_done, timeout, and the watchdog counter are cleared on entry.
- RUN:
  - cpu_reset=1; the watchdog counts each cycle.
  - cpu_hlt=1 -> HALTED with run_done=1. HLT takes precedence over a simultaneous watchdog expiry.
  - If MAX_RUN>0 and the count reaches MAX_RUN -> HALTED with timeout=1, and cpu_reset goes to 0 the same edge.
  - host_req is ignored in RUN: no ack and no write, because the CPU owns the RAM. start is ignored.
- HALTED:
  - cpu_reset holds its exit value (1 after HLT so OUT register stays visible; 0 after timeout).
  - host_req -> LOAD: cpu_reset=0, flags cleared, bytes_loaded cleared.
  - Otherwise start -> SETTLE (re-run).
  - If both are high, host_req wins.
- busy=1 exactly in LOAD and SETTLE.

Test Plan:
- Reset low 1 cycle, then high -> cpu_reset=0, input_mode=0, host_ack=0, state IDLE, all counters 0.
- Load beats 9h=0Bh, Ah=0Bh, 0h=79h, then last 1h=30h -> four single-cycle input_mode pulses with matching address/data; bytes_loaded=4; busy until SETTLE ends; cpu_reset rises exactly SETTLE_CYCLES=2 cycles after the last ack.
- Hold host_req high for 5 cycles on one beat -> exactly one input_mode pulse and one host_ack; bytes_loaded increments by 1.
- In RUN, pulse host_req with addr 3h/data FFh -> no ack, no input_mode; then cpu_hlt=1 -> run_done=1, cpu_reset stays 1.
- MAX_RUN=20 with cpu_hlt held 0 -> timeout=1 and cpu_reset=0 on cycle 20 of RUN; start then -> SETTLE, flags cleared.
- Assert reset mid-LOAD, one cycle after host_req -> no write strobe, host_ack=0, state IDLE; 17 beats in a later load -> bytes_loaded saturates at 16.
